// File: rtl/fifo_param.sv
// Parametrised synchronous show-ahead FIFO with an exact fill count and programmable almost flags.
// Define FIFO_PARAM_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_param #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned AF_THRESH  = 28,
    parameter int unsigned AE_THRESH  = 4
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 sclr,
    input  logic                 wrreq,
    input  logic [WIDTH-1:0]     data,
    input  logic                 rdreq,
    output logic [WIDTH-1:0]     q,
    output logic [DEPTH_LOG2:0]  usedw,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 almost_empty
`ifdef FIFO_PARAM_ERR_FLAGS_EN
    ,
    output logic                 overflow,
    output logic                 underflow
`endif
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] AF_LVL = AF_THRESH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] AE_LVL = AE_THRESH[DEPTH_LOG2:0];

    logic [WIDTH-1:0]      ram [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  do_write;
    logic                  do_read;

    // Extra wrap bit on each pointer lets full and empty be told apart when the addresses match.
    always_comb begin
        wr_addr      = wr_ptr[DEPTH_LOG2-1:0];
        rd_addr      = rd_ptr[DEPTH_LOG2-1:0];
        usedw        = wr_ptr - rd_ptr;
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) && (wr_addr == rd_addr);
        almost_full  = (usedw >= AF_LVL);
        almost_empty = (usedw <= AE_LVL);
        do_read      = rdreq && !empty;
        do_write     = wrreq && (!full || rdreq);
        q            = ram[rd_addr];
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage has no reset so it maps onto asynchronous-read LUT RAM.
    always_ff @(posedge clk) begin
        if (do_write && !sclr) ram[wr_addr] <= data;
    end

`ifdef FIFO_PARAM_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (sclr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wrreq && full && !rdreq) overflow  <= 1'b1;
            if (rdreq && empty)          underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: queue-based occupancy model compared every cycle plus directed literal checks.
module tb_fifo_param;
    localparam int DEPTH_A = 32;
    localparam int DEPTH_B = 8;

    logic        clk = 1'b0;
    logic        aclr_a = 1'b1, sclr_a = 1'b0, wr_a = 1'b0, rd_a = 1'b0;
    logic [7:0]  data_a = '0;
    logic [7:0]  q_a;
    logic [5:0]  usedw_a;
    logic        empty_a, full_a, af_a, ae_a;
    logic        aclr_b = 1'b1, sclr_b = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
    logic [15:0] data_b = '0;
    logic [15:0] q_b;
    logic [3:0]  usedw_b;
    logic        empty_b, full_b, af_b, ae_b;
`ifdef FIFO_PARAM_ERR_FLAGS_EN
    logic        ovf_a, unf_a, ovf_b, unf_b;
`endif

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    fifo_param u_a (
        .clk(clk), .aclr(aclr_a), .sclr(sclr_a), .wrreq(wr_a), .data(data_a), .rdreq(rd_a),
        .q(q_a), .usedw(usedw_a), .empty(empty_a), .full(full_a),
        .almost_full(af_a), .almost_empty(ae_a)
`ifdef FIFO_PARAM_ERR_FLAGS_EN
        , .overflow(ovf_a), .underflow(unf_a)
`endif
    );

    fifo_param #(.WIDTH(16), .DEPTH_LOG2(3), .AF_THRESH(6), .AE_THRESH(2)) u_b (
        .clk(clk), .aclr(aclr_b), .sclr(sclr_b), .wrreq(wr_b), .data(data_b), .rdreq(rd_b),
        .q(q_b), .usedw(usedw_b), .empty(empty_b), .full(full_b),
        .almost_full(af_b), .almost_empty(ae_b)
`ifdef FIFO_PARAM_ERR_FLAGS_EN
        , .overflow(ovf_b), .underflow(unf_b)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: an ordered list of stored words plus sticky error bits.
    logic [7:0]  ma[$];
    logic [15:0] mb[$];
    bit ov_a, un_a, ov_b, un_b;

    always @(posedge clk or posedge aclr_a) begin : model_a
        bit acc_w, acc_r;
        if (aclr_a || sclr_a) begin
            ma.delete();
            ov_a <= 1'b0;
            un_a <= 1'b0;
        end else begin
            acc_r = rd_a && ma.size() > 0;
            acc_w = wr_a && (ma.size() < DEPTH_A || rd_a);
            if (wr_a && ma.size() == DEPTH_A && !rd_a) ov_a <= 1'b1;
            if (rd_a && ma.size() == 0) un_a <= 1'b1;
            if (acc_r) void'(ma.pop_front());
            if (acc_w) ma.push_back(data_a);
        end
    end

    always @(posedge clk or posedge aclr_b) begin : model_b
        bit acc_w, acc_r;
        if (aclr_b || sclr_b) begin
            mb.delete();
            ov_b <= 1'b0;
            un_b <= 1'b0;
        end else begin
            acc_r = rd_b && mb.size() > 0;
            acc_w = wr_b && (mb.size() < DEPTH_B || rd_b);
            if (wr_b && mb.size() == DEPTH_B && !rd_b) ov_b <= 1'b1;
            if (rd_b && mb.size() == 0) un_b <= 1'b1;
            if (acc_r) void'(mb.pop_front());
            if (acc_w) mb.push_back(data_b);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_usedw", int'(usedw_a), ma.size());
            chk("a_empty", int'(empty_a), int'(ma.size() == 0));
            chk("a_full",  int'(full_a),  int'(ma.size() == DEPTH_A));
            chk("a_af",    int'(af_a),    int'(ma.size() >= 28));
            chk("a_ae",    int'(ae_a),    int'(ma.size() <= 4));
            if (ma.size() != 0) chk("a_q", int'(q_a), int'(ma[0]));
            chk("b_usedw", int'(usedw_b), mb.size());
            chk("b_empty", int'(empty_b), int'(mb.size() == 0));
            chk("b_full",  int'(full_b),  int'(mb.size() == DEPTH_B));
            chk("b_af",    int'(af_b),    int'(mb.size() >= 6));
            chk("b_ae",    int'(ae_b),    int'(mb.size() <= 2));
            if (mb.size() != 0) chk("b_q", int'(q_b), int'(mb[0]));
`ifdef FIFO_PARAM_ERR_FLAGS_EN
            chk("a_ovf", int'(ovf_a), int'(ov_a));
            chk("a_unf", int'(unf_a), int'(un_a));
            chk("b_ovf", int'(ovf_b), int'(ov_b));
            chk("b_unf", int'(unf_b), int'(un_b));
`endif
        end
    end

    task automatic a_drive(input logic s, input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        sclr_a = s; wr_a = w; rd_a = r; data_a = d;
    endtask

    task automatic a_read_expect(input string nm, input logic [7:0] e);
        @(negedge clk);
        chk(nm, int'(q_a), int'(e));
        sclr_a = 1'b0; wr_a = 1'b0; rd_a = 1'b1;
    endtask

    initial begin : stim
        int wr_n, rd_n;
        logic w, r;
        repeat (2) @(posedge clk);
        @(negedge clk);
        aclr_a = 1'b0;
        aclr_b = 1'b0;
        cmp_en = 1'b1;
        chk("rst_usedw", int'(usedw_a), 0);
        chk("rst_empty", int'(empty_a), 1);
        chk("rst_full",  int'(full_a), 0);
        chk("rst_ae",    int'(ae_a), 1);
        chk("rst_af",    int'(af_a), 0);

        // Mid-cycle aclr with seven words stored.
        for (int i = 0; i < 7; i++) a_drive(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        @(posedge clk);
        #2 aclr_a = 1'b1;
        #1;
        chk("aclr_usedw", int'(usedw_a), 0);
        chk("aclr_empty", int'(empty_a), 1);
        chk("aclr_ae",    int'(ae_a), 1);
        chk("aclr_full",  int'(full_a), 0);
        #1 aclr_a = 1'b0;
        a_drive(1'b0, 1'b1, 1'b0, 8'h77);
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        a_read_expect("post_aclr_q", 8'h77);
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill to full, drop the 33rd write, then drain in order.
        for (int i = 0; i < 32; i++) begin
            a_drive(1'b0, 1'b1, 1'b0, 8'(i));
            if (i == 28) chk("af_at_28", int'(af_a), 1);
            if (i == 28) chk("usedw_at_28", int'(usedw_a), 28);
        end
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fill_usedw", int'(usedw_a), 32);
        chk("fill_full",  int'(full_a), 1);
        a_drive(1'b0, 1'b1, 1'b0, 8'hAA);
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("drop_usedw", int'(usedw_a), 32);
        chk("drop_q",     int'(q_a), 0);
        for (int i = 0; i < 32; i++) a_read_expect("drain_q", 8'(i));
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("drain_empty", int'(empty_a), 1);

        // Simultaneous read/write while full keeps the count at depth.
        for (int i = 0; i < 32; i++) a_drive(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        a_drive(1'b0, 1'b1, 1'b1, 8'h55);
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fullrw_usedw", int'(usedw_a), 32);
        chk("fullrw_full",  int'(full_a), 1);
        chk("fullrw_q",     int'(q_a), 8'h41);
        for (int i = 1; i < 32; i++) a_read_expect("fullrw_drain", 8'(8'h40 + i));
        a_read_expect("fullrw_last", 8'h55);
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fullrw_empty", int'(empty_a), 1);

        // Simultaneous read/write while empty: write only, no bypass.
        a_drive(1'b0, 1'b1, 1'b1, 8'h3C);
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("emptyrw_usedw", int'(usedw_a), 1);
        chk("emptyrw_empty", int'(empty_a), 0);
        chk("emptyrw_q",     int'(q_a), 8'h3C);

        // sclr beats a concurrent write.
        a_drive(1'b1, 1'b1, 1'b0, 8'h99);
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("sclr_usedw", int'(usedw_a), 0);
        chk("sclr_empty", int'(empty_a), 1);

`ifdef FIFO_PARAM_ERR_FLAGS_EN
        for (int i = 0; i < 32; i++) a_drive(1'b0, 1'b1, 1'b0, 8'(i));
        a_drive(1'b0, 1'b1, 1'b0, 8'hEE);
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_set", int'(ovf_a), 1);
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_sticky", int'(ovf_a), 1);
        chk("unf_clear", int'(unf_a), 0);
        for (int i = 0; i < 32; i++) a_read_expect("err_drain", 8'(i));
        a_drive(1'b0, 1'b0, 1'b1, 8'h00);
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("unf_set", int'(unf_a), 1);
        chk("ovf_kept", int'(ovf_a), 1);
        a_drive(1'b1, 1'b0, 1'b0, 8'h00);
        a_drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_sclr", int'(ovf_a), 0);
        chk("unf_sclr", int'(unf_a), 0);
`endif

        // Small FIFO: random 50% write/read stream of 100 words across many wraps.
        wr_n = 0;
        rd_n = 0;
        for (int cyc = 0; cyc < 3000 && rd_n < 100; cyc++) begin
            @(negedge clk);
            w = 1'($urandom_range(0, 1)) && (wr_n < 100);
            r = 1'($urandom_range(0, 1));
            if (r && mb.size() > 0) begin
                chk("b_order", int'(q_b), 32'hA000 + rd_n);
                rd_n++;
            end
            data_b = 16'(32'hA000 + wr_n);
            wr_b = w;
            rd_b = r;
            if (w && (mb.size() < DEPTH_B || r)) wr_n++;
        end
        @(negedge clk);
        wr_b = 1'b0;
        rd_b = 1'b0;
        chk("b_words_out", rd_n, 100);
        @(negedge clk);
        chk("b_final_usedw", int'(usedw_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
